// File: rtl/vga_clock_pkg.sv
// Shared types and field widths for the VGA clock timekeeping blocks.
// wrap_add keeps every modular increment as a compare-and-subtract instead of a divider.
package vga_clock_pkg;

  typedef enum logic [1:0] {
    AL_OFF     = 2'd0,
    AL_ARMED   = 2'd1,
    AL_RINGING = 2'd2,
    AL_SNOOZED = 2'd3
  } al_state_e;

  localparam int          SEC_W       = 6;
  localparam int          MIN_W       = 6;
  localparam int          HR_W        = 5;
  localparam int unsigned SEC_PER_MIN = 60;

  // Valid for v < m and a <= m, which covers tick + adjust on every field.
  function automatic int unsigned wrap_add(input int unsigned v, input int unsigned a,
                                           input int unsigned m);
    int unsigned s;
    s = v + a;
    return (s >= m) ? s - m : s;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm: hh:mm setting, OFF/ARMED/RINGING/SNOOZED state machine,
// snooze countdown and ring-timeout counter. State is exported for decoding and debug.
module alarm_channel
  import vga_clock_pkg::*;
#(
  parameter int unsigned HR_MOD       = 12,
  parameter int unsigned SNOOZE_TICKS = 300,
  parameter int unsigned RING_TICKS   = 600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             sel,
  input  logic             min_inc,
  input  logic             hour_inc,
  input  logic             toggle,
  input  logic             snooze,
  input  logic             dismiss,
  input  logic [HR_W-1:0]  now_hours,
  input  logic [MIN_W-1:0] now_minutes,
  input  logic [SEC_W-1:0] now_seconds,
  output logic [MIN_W-1:0] al_minutes,
  output logic [HR_W-1:0]  al_hours,
  output al_state_e        state
);

  localparam int SNZ_W = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS + 1) : 1;
  localparam int RNG_W = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;

  al_state_e        state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [HR_W-1:0]  hr_q, hr_d;
  logic [SNZ_W-1:0] snz_q, snz_d;
  logic [RNG_W-1:0] ring_q, ring_d;
  logic             match;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    hr_d    = hr_q;
    snz_d   = snz_q;
    ring_d  = ring_q;
    if (sel && min_inc) min_d = MIN_W'(wrap_add(32'(min_q), 1, SEC_PER_MIN));
    if (sel && hour_inc) hr_d = HR_W'(wrap_add(32'(hr_q), 1, HR_MOD));
    // Only second 00 matches, so a dismissed alarm stays quiet for the rest of its minute.
    match = tick && (now_hours == hr_q) && (now_minutes == min_q) && (now_seconds == '0);
    case (state_q)
      AL_OFF: if (sel && toggle) state_d = AL_ARMED;
      AL_ARMED: begin
        if (sel && toggle) state_d = AL_OFF;
        else if (match) begin
          state_d = AL_RINGING;
          ring_d  = '0;
        end
      end
      AL_RINGING: begin
        if (sel && toggle) state_d = AL_OFF;
        else if (dismiss) state_d = AL_ARMED;
        else if (snooze) begin
          state_d = AL_SNOOZED;
          snz_d   = SNZ_W'(SNOOZE_TICKS);
        end else if (tick) begin
          if (ring_q == RNG_W'(RING_TICKS - 1)) state_d = AL_ARMED;
          else ring_d = ring_q + RNG_W'(1);
        end
      end
      AL_SNOOZED: begin
        if (sel && toggle) state_d = AL_OFF;
        else if (dismiss) state_d = AL_ARMED;
        else if (tick) begin
          if (snz_q <= SNZ_W'(1)) begin
            state_d = AL_RINGING;
            ring_d  = '0;
          end else snz_d = snz_q - SNZ_W'(1);
        end
      end
      default: state_d = AL_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AL_OFF;
      min_q   <= '0;
      hr_q    <= '0;
      snz_q   <= '0;
      ring_q  <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      snz_q   <= snz_d;
      ring_q  <= ring_d;
    end
  end

  assign al_minutes = min_q;
  assign al_hours   = hr_q;
  assign state      = state_q;

endmodule

// File: rtl/timekeeper_core.sv
// Timekeeping and alarm engine: 1 Hz prescaler, hh:mm:ss carry chain, tone divider
// and NUM_ALARMS alarm channels. Pulse inputs are single-cycle; there are no handshakes.
module timekeeper_core
  import vga_clock_pkg::*;
#(
  parameter int CLK_HZ           = 31_500_000,
  parameter int TONE_HZ          = 1575,
  parameter int NUM_ALARMS       = 2,
  parameter int MODE_24H         = 0,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sec_inc,
  input  logic                        min_inc,
  input  logic                        hour_inc,
  input  logic [AW-1:0]               al_sel,
  input  logic                        al_min_inc,
  input  logic                        al_hour_inc,
  input  logic                        al_toggle,
  input  logic                        snooze,
  input  logic                        dismiss,
  output logic [SEC_W-1:0]            seconds,
  output logic [MIN_W-1:0]            minutes,
  output logic [HR_W-1:0]             hours,
  output logic [MIN_W*NUM_ALARMS-1:0] al_minutes,
  output logic [HR_W*NUM_ALARMS-1:0]  al_hours,
  output logic [NUM_ALARMS-1:0]       al_on,
  output logic [NUM_ALARMS-1:0]       ringing,
  output logic                        sec_tick,
  output logic                        blink,
  output logic                        buzzer_out
);

  localparam int          PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int          TONE_DIV_RAW = CLK_HZ / (2 * TONE_HZ);
  localparam int          TONE_DIV     = (TONE_DIV_RAW > 1) ? TONE_DIV_RAW : 1;
  localparam int          TW           = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int unsigned HR_MOD       = (MODE_24H != 0) ? 24 : 12;

  logic [PW-1:0]    presc_q, presc_d;
  logic [TW-1:0]    tone_cnt_q, tone_cnt_d;
  logic             tone_q, tone_d, blink_q, blink_d, sec_tick_q;
  logic [SEC_W-1:0] seconds_q, seconds_d;
  logic [MIN_W-1:0] minutes_q, minutes_d;
  logic [HR_W-1:0]  hours_q, hours_d;
  logic             tick, sec_carry, min_carry;
  al_state_e        ch_state [NUM_ALARMS];

  always_comb begin
    tick       = (presc_q == PW'(CLK_HZ - 1));
    presc_d    = tick ? '0 : presc_q + PW'(1);
    blink_d    = (presc_d < PW'(CLK_HZ / 2));
    tone_cnt_d = (tone_cnt_q == TW'(TONE_DIV - 1)) ? '0 : tone_cnt_q + TW'(1);
    tone_d     = (tone_cnt_q == TW'(TONE_DIV - 1)) ? ~tone_q : tone_q;
    // Only the tick path carries; manual adjust pulses wrap their own field silently.
    sec_carry  = tick && (seconds_q == SEC_W'(SEC_PER_MIN - 1));
    min_carry  = sec_carry && (minutes_q == MIN_W'(SEC_PER_MIN - 1));
    seconds_d  = SEC_W'(wrap_add(32'(seconds_q), 32'(tick) + 32'(sec_inc), SEC_PER_MIN));
    minutes_d  = MIN_W'(wrap_add(32'(minutes_q), 32'(sec_carry) + 32'(min_inc), SEC_PER_MIN));
    hours_d    = HR_W'(wrap_add(32'(hours_q), 32'(min_carry) + 32'(hour_inc), HR_MOD));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      blink_q    <= 1'b0;
      sec_tick_q <= 1'b0;
      seconds_q  <= '0;
      minutes_q  <= '0;
      hours_q    <= '0;
    end else begin
      presc_q    <= presc_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      blink_q    <= blink_d;
      sec_tick_q <= tick;
      seconds_q  <= seconds_d;
      minutes_q  <= minutes_d;
      hours_q    <= hours_d;
    end
  end

  // Channels compare against the next time so RINGING appears on the same edge as hh:mm:00.
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
    alarm_channel #(
      .HR_MOD      (HR_MOD),
      .SNOOZE_TICKS(SNOOZE_MIN * SEC_PER_MIN),
      .RING_TICKS  (RING_TIMEOUT_MIN * SEC_PER_MIN)
    ) u_chan (
      .clk        (clk),
      .rst        (reset),
      .tick       (tick),
      .sel        (al_sel == AW'(i)),
      .min_inc    (al_min_inc),
      .hour_inc   (al_hour_inc),
      .toggle     (al_toggle),
      .snooze     (snooze),
      .dismiss    (dismiss),
      .now_hours  (hours_d),
      .now_minutes(minutes_d),
      .now_seconds(seconds_d),
      .al_minutes (al_minutes[MIN_W*i +: MIN_W]),
      .al_hours   (al_hours[HR_W*i +: HR_W]),
      .state      (ch_state[i])
    );
    assign al_on[i]   = (ch_state[i] != AL_OFF);
    assign ringing[i] = (ch_state[i] == AL_RINGING);
  end

  assign seconds    = seconds_q;
  assign minutes    = minutes_q;
  assign hours      = hours_q;
  assign sec_tick   = sec_tick_q;
  assign blink      = blink_q;
  assign buzzer_out = tone_q & blink_q & (|ringing);

endmodule
